// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core's load-store path.
//   remote_req_s             : remote request as produced by the LSU
//   bsg_manycore_load_info_s : load/fetch qualifiers carried with a request
//   lsu_remote_buf_state_e   : fence drain state of the remote request buffer
package bsg_vanilla_pkg;

    localparam int data_width_gp   = 32;
    localparam int addr_width_gp   = 32;
    localparam int reg_id_width_gp = 5;

    typedef struct packed {
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
        logic       icache_fetch;
    } bsg_manycore_load_info_s;

    typedef struct packed {
        logic                         write_not_read;
        logic                         is_amo_op;
        logic [3:0]                   amo_type;
        logic                         amo_aq;
        logic                         amo_rl;
        logic [3:0]                   mask;
        bsg_manycore_load_info_s      load_info;
        logic [reg_id_width_gp-1:0]   reg_id;
        logic [data_width_gp-1:0]     data;
        logic [addr_width_gp-1:0]     addr;
    } remote_req_s;

    typedef enum logic {
        IDLE,
        DRAIN
    } lsu_remote_buf_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready enqueue and valid/yumi dequeue.
//   v_i/ready_o/data_i : enqueue side, write happens when v_i & ready_o
//   v_o/data_o/yumi_i  : dequeue side, yumi_i pops the head (only when v_o)
// ready_o and v_o come straight from the registered occupancy count, so a
// pop in the same cycle does not make room for a push.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic [width_p-1:0]  mem_q [els_p];
    logic                enq, deq;

    assign ready_o = (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + ptr_w_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + ptr_w_lp'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count makes stale entries unobservable and this keeps it plain flops/RAM.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lsu_remote_credit_counter.sv
// Outstanding-request credit counter.
//   issue_i   : one request left for the network (consumes a credit)
//   return_i  : one request was acknowledged (restores a credit)
//   credits_o : credits currently available
//   full_o    : credits_o == max_out_credits_p (nothing outstanding)
// A return with nothing outstanding is a protocol error; the counter holds
// at max rather than wrapping.
module lsu_remote_credit_counter #(
    parameter int max_out_credits_p = 32,
    parameter int credit_width_p    = $clog2(max_out_credits_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      issue_i,
    input  logic                      return_i,
    output logic [credit_width_p-1:0] credits_o,
    output logic                      full_o
);

    localparam logic [credit_width_p-1:0] max_lp = credit_width_p'(max_out_credits_p);

    logic [credit_width_p-1:0] credits_q, credits_d;

    assign credits_o = credits_q;
    assign full_o    = (credits_q == max_lp);

    always_comb begin
        credits_d = credits_q;
        if (issue_i & ~return_i) begin
            credits_d = credits_q - credit_width_p'(1);
        end else if (return_i & ~issue_i & ~full_o) begin
            credits_d = credits_q + credit_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q <= max_lp;
        end else begin
            credits_q <= credits_d;
        end
    end

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(return_i && full_o))
                else $error("[BSG_ERROR] credit returned with no request outstanding");
        end
    end

endmodule

// File: rtl/lsu_remote_req_buffer.sv
// Remote request buffer between the LSU and the network TX endpoint.
//   remote_req_i/remote_req_v_i : request from the LSU, re-presented while stalled
//   fence_i                     : a fence is in EXE
//   stall_o                     : hold the EXE instruction
//   out_packet_o/out_v_o/out_ready_i : request stream to network TX
//   credit_return_i             : one outstanding request acknowledged (pulse)
//   out_credits_o               : credits currently available
//   drained_o                   : FIFO empty and all credits returned
// Requests leave in arrival order. A fence stalls until everything buffered
// has issued and been acknowledged; no implicit fencing is added for AMOs.
module lsu_remote_req_buffer
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int fifo_els_p        = 2,
    parameter int max_out_credits_p = 32,
    parameter int credit_width_p    = $clog2(max_out_credits_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  remote_req_s               remote_req_i,
    input  logic                      remote_req_v_i,
    input  logic                      fence_i,
    output logic                      stall_o,
    output remote_req_s               out_packet_o,
    output logic                      out_v_o,
    input  logic                      out_ready_i,
    input  logic                      credit_return_i,
    output logic [credit_width_p-1:0] out_credits_o,
    output logic                      drained_o
);

    if (data_width_p != data_width_gp) begin : g_bad_data_width
        $error("data_width_p must match the remote_req_s payload width");
    end
    if (fifo_els_p < 2) begin : g_bad_fifo_els
        $error("fifo_els_p must be at least 2");
    end
    if (max_out_credits_p < 1) begin : g_bad_credits
        $error("max_out_credits_p must be at least 1");
    end

    lsu_remote_buf_state_e state_q, state_d;

    logic fifo_ready, fifo_v, enq, issue, credits_full;

    // Enqueue only looks at the registered full flag, so a dequeue in the
    // same cycle does not let a new request in (keeps stall off the
    // network-ready path).
    assign enq     = remote_req_v_i & fifo_ready & (state_q == IDLE);
    assign out_v_o = fifo_v & (out_credits_o != '0);
    assign issue   = out_v_o & out_ready_i;

    assign drained_o = ~fifo_v & credits_full;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(remote_req_s)),
        .els_p   (fifo_els_p)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq),
        .ready_o   (fifo_ready),
        .data_i    (remote_req_i),
        .v_o       (fifo_v),
        .data_o    (out_packet_o),
        .yumi_i    (issue)
    );

    lsu_remote_credit_counter #(
        .max_out_credits_p (max_out_credits_p),
        .credit_width_p    (credit_width_p)
    ) u_credits (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .issue_i   (issue),
        .return_i  (credit_return_i),
        .credits_o (out_credits_o),
        .full_o    (credits_full)
    );

    // DRAIN releases the stall in the same cycle drained_o rises so the
    // fence retires without an extra bubble.
    always_comb begin
        state_d = state_q;
        stall_o = remote_req_v_i & ~fifo_ready;
        case (state_q)
            IDLE: begin
                if (fence_i & ~drained_o) begin
                    stall_o = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained_o) begin
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_lsu_remote_req_buffer.sv
module tb_lsu_remote_req_buffer;
    import bsg_vanilla_pkg::*;

    localparam int MAX = 32;
    localparam int ELS = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic              clk = 1'b0;
    logic              reset_n_i;
    remote_req_s       remote_req_i;
    logic              remote_req_v_i;
    logic              fence_i;
    logic              stall_o;
    remote_req_s       out_packet_o;
    logic              out_v_o;
    logic              out_ready_i;
    logic              credit_return_i;
    logic [CW-1:0]     out_credits_o;
    logic              drained_o;

    always #5 clk = ~clk;

    lsu_remote_req_buffer #(
        .data_width_p      (32),
        .fifo_els_p        (ELS),
        .max_out_credits_p (MAX)
    ) u_dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .remote_req_i    (remote_req_i),
        .remote_req_v_i  (remote_req_v_i),
        .fence_i         (fence_i),
        .stall_o         (stall_o),
        .out_packet_o    (out_packet_o),
        .out_v_o         (out_v_o),
        .out_ready_i     (out_ready_i),
        .credit_return_i (credit_return_i),
        .out_credits_o   (out_credits_o),
        .drained_o       (drained_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the buffer is a bounded in-order queue, credits are
    // an integer, and "draining" is whether a fence is waiting.
    remote_req_s mq[$];
    int          mcred  = MAX;
    bit          mdrain = 0;

    function automatic remote_req_s rand_req();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return remote_req_s'(t[$bits(remote_req_s)-1:0]);
    endfunction

    // Drive one cycle, check outputs mid-cycle, then advance the model.
    task automatic step(input bit v, input remote_req_s r, input bit f,
                        input bit rdy, input bit ret, output bit exp_stall);
        bit drained, full, exp_ov, fire, enq;
        remote_req_v_i  = v;
        remote_req_i    = r;
        fence_i         = f;
        out_ready_i     = rdy;
        credit_return_i = ret;
        drained   = (mq.size() == 0) && (mcred == MAX);
        full      = (mq.size() == ELS);
        exp_ov    = (mq.size() > 0) && (mcred > 0);
        exp_stall = (v && full) || (mdrain ? !drained : (f && !drained));
        @(negedge clk);
        check("out_v", 128'(out_v_o), 128'(exp_ov));
        if (exp_ov) check("out_packet", 128'(out_packet_o), 128'(mq[0]));
        check("stall", 128'(stall_o), 128'(exp_stall));
        check("credits", 128'(out_credits_o), 128'(mcred));
        check("drained", 128'(drained_o), 128'(drained));
        @(posedge clk);
        #1;
        fire = exp_ov && rdy;
        enq  = v && !full && !mdrain;
        if (fire) void'(mq.pop_front());
        if (enq) mq.push_back(r);
        mcred = mcred - int'(fire) + int'(ret);
        if (mcred > MAX) mcred = MAX;
        if (!mdrain && f && !drained) mdrain = 1;
        else if (mdrain && drained)   mdrain = 0;
    endtask

    // Present a request until it is accepted, like the LSU under stall.
    task automatic send(input remote_req_s r, input bit rdy);
        bit st;
        for (int n = 0; n < 40; n++) begin
            step(1, r, 0, rdy, 0, st);
            if (!st) return;
        end
        check("send_timeout", 128'(1), 128'(0));
    endtask

    task automatic idle(input bit rdy, input bit ret);
        bit st;
        step(0, '0, 0, rdy, ret, st);
    endtask

    initial begin
        bit          st;
        remote_req_s a, b, c;
        int          n;
        bit          pend_req, pend_fence;
        remote_req_s pr;

        reset_n_i       = 1'b0;
        remote_req_i    = '0;
        remote_req_v_i  = 1'b0;
        fence_i         = 1'b0;
        out_ready_i     = 1'b0;
        credit_return_i = 1'b0;
        #12;
        check("rst_out_v", 128'(out_v_o), 128'(0));
        check("rst_stall", 128'(stall_o), 128'(0));
        check("rst_credits", 128'(out_credits_o), 128'(MAX));
        check("rst_drained", 128'(drained_o), 128'(1));
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;

        // Single store: no bypass, then issue, then the credit comes back.
        a = rand_req();
        step(1, a, 0, 1, 0, st);
        idle(1, 0);
        check("t_single_cred31", 128'(out_credits_o), 128'(MAX - 1));
        idle(0, 1);
        check("t_single_cred32", 128'(out_credits_o), 128'(MAX));
        check("t_single_drained", 128'(drained_o), 128'(1));

        // Three loads into a 2-deep FIFO with the network blocked.
        a = rand_req(); b = rand_req(); c = rand_req();
        step(1, a, 0, 0, 0, st);
        step(1, b, 0, 0, 0, st);
        step(1, c, 0, 0, 0, st);
        step(1, c, 0, 1, 0, st);
        step(1, c, 0, 1, 0, st);
        for (int i = 0; i < 4; i++) idle(1, 0);
        check("t_abc_cred", 128'(out_credits_o), 128'(MAX - 3));

        // Exhaust credits, then a queued request must wait for a return.
        n = 0;
        while (mcred > 0 && n < 200) begin
            step(1, rand_req(), 0, 1, 0, st);
            n++;
        end
        check("t_exhaust_reached", 128'(mcred), 128'(0));
        send(rand_req(), 1);
        idle(1, 0);
        check("t_zero_cred_held", 128'(out_v_o), 128'(0));
        idle(1, 1);
        idle(1, 0);
        check("t_zero_cred_after", 128'(out_credits_o), 128'(0));
        n = 0;
        while (mq.size() > 0 && n < 50) begin
            idle(1, mcred == 0);
            n++;
        end
        while (mcred < 5) idle(0, 1);

        // Issue and return in the same cycle at credits=5.
        send(rand_req(), 0);
        idle(1, 1);
        check("t_issue_ret_5", 128'(out_credits_o), 128'(5));
        while (mcred < MAX) idle(0, 1);

        // Fence with 2 outstanding and 1 queued.
        send(rand_req(), 1);
        send(rand_req(), 1);
        idle(1, 0);
        send(rand_req(), 0);
        step(0, '0, 1, 0, 0, st);
        check("t_fence_stall", 128'(stall_o), 128'(1));
        n = 0;
        st = 1;
        while (st && n < 40) begin
            step(0, '0, 1, 1, mcred < MAX, st);
            n++;
        end
        check("t_fence_released", 128'(st), 128'(0));
        check("t_fence_drained", 128'(drained_o), 128'(1));
        step(0, '0, 1, 0, 0, st);
        check("t_fence_when_drained", 128'(stall_o), 128'(0));

        // Async reset mid-drain with the FIFO full.
        send(rand_req(), 0);
        send(rand_req(), 0);
        step(0, '0, 1, 0, 0, st);
        check("t_drain_full_stall", 128'(stall_o), 128'(1));
        #2;
        reset_n_i = 1'b0;
        #1;
        check("t_arst_out_v", 128'(out_v_o), 128'(0));
        check("t_arst_stall", 128'(stall_o), 128'(0));
        check("t_arst_credits", 128'(out_credits_o), 128'(MAX));
        check("t_arst_drained", 128'(drained_o), 128'(1));
        mq.delete();
        mcred  = MAX;
        mdrain = 0;
        fence_i = 1'b0;
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        idle(1, 0);

        // Randomized traffic: LSU holds a request or fence until unstalled.
        pend_req   = 0;
        pend_fence = 0;
        pr         = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pend_req && !pend_fence) begin
                n = int'($urandom_range(0, 9));
                if (n < 5) begin
                    pend_req = 1;
                    pr = rand_req();
                end else if (n == 5) begin
                    pend_fence = 1;
                end
            end
            step(pend_req, pend_req ? pr : '0, pend_fence,
                 $urandom_range(0, 9) < 7,
                 (mcred < MAX) && ($urandom_range(0, 2) == 0), st);
            if (!st) begin
                pend_req   = 0;
                pend_fence = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
